// File: rtl/e3_pkg.sv
// Shared constants, FSM state type and excess-3 helpers for the serial x9 multiplier.
package e3_pkg;

  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] E3_MIN    = 4'b0011;
  localparam logic [3:0] E3_MAX    = 4'b1100;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic e3_is_valid(input logic [3:0] code);
    return (code >= E3_MIN) && (code <= E3_MAX);
  endfunction

endpackage

// File: rtl/e3_digit_mac.sv
// One decimal multiply-accumulate step: digit*9 + carry, split into excess-3 units and binary tens.
module e3_digit_mac
  import e3_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [3:0] carry,
  output logic [3:0] units_e3,
  output logic [3:0] tens,
  output logic       invalid
);

  logic [3:0] value;
  logic [6:0] product;
  logic [3:0] units;

  always_comb begin
    invalid = !e3_is_valid(digit);
    value   = invalid ? 4'd0 : (digit - E3_OFFSET);
    product = 7'(value) * 7'd9 + 7'(carry);
    // product never exceeds 89, so tens is found by thresholding instead of a divider
    tens = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      if (product >= 7'(10 * i)) tens = 4'(i);
    end
    units    = 4'(product - 7'(tens) * 7'd10);
    units_e3 = units + E3_OFFSET;
  end

endmodule

// File: rtl/e3_mult_9_seq.sv
// Serial excess-3 x9 multiplier, LSD-first digit streams on valid/ready on both sides.
// Optional build macro E3_MULT_SEQ_ZERO_SUPPRESS_EN drops a zero final tens digit.
//
// Handshake: a beat transfers on a rising edge where valid && ready; the sender
// keeps data stable while valid && !ready, and the output register never changes
// while out_valid && !out_ready.
module e3_mult_9_seq
  import e3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_digit,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_digit,
  output logic       out_last,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready
);

  state_t     state, state_nxt;
  logic [3:0] carry, carry_nxt;
  logic       err, err_nxt;
  logic [3:0] out_digit_nxt;
  logic       out_last_nxt, out_err_nxt, out_valid_nxt;

  logic [3:0] mac_units_e3;
  logic [3:0] mac_tens;
  logic       mac_invalid;
  logic       in_fire, out_fire;
  logic       err_sum;
  logic       suppress;

  e3_digit_mac u_mac (
    .digit    (in_digit),
    .carry    (carry),
    .units_e3 (mac_units_e3),
    .tens     (mac_tens),
    .invalid  (mac_invalid)
  );

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign err_sum  = err | mac_invalid;

`ifdef E3_MULT_SEQ_ZERO_SUPPRESS_EN
  assign suppress = (mac_tens == 4'd0);
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    carry_nxt     = carry;
    err_nxt       = err;
    out_digit_nxt = out_digit;
    out_last_nxt  = out_last;
    out_err_nxt   = out_err;
    out_valid_nxt = out_valid;

    if (out_fire) out_valid_nxt = 1'b0;

    case (state)
      RUN: begin
        if (in_fire) begin
          out_digit_nxt = mac_units_e3;
          out_last_nxt  = 1'b0;
          out_err_nxt   = 1'b0;
          out_valid_nxt = 1'b1;
          if (!in_last) begin
            carry_nxt = mac_tens;
            err_nxt   = err_sum;
          end else if (suppress) begin
            out_last_nxt = 1'b1;
            out_err_nxt  = err_sum;
            carry_nxt    = 4'd0;
            err_nxt      = 1'b0;
          end else begin
            carry_nxt = mac_tens;
            err_nxt   = err_sum;
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        // the units beat is always pending here; the tens beat follows its handshake
        if (out_fire) begin
          out_digit_nxt = carry + E3_OFFSET;
          out_last_nxt  = 1'b1;
          out_err_nxt   = err;
          out_valid_nxt = 1'b1;
          carry_nxt     = 4'd0;
          err_nxt       = 1'b0;
          state_nxt     = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      carry     <= 4'd0;
      err       <= 1'b0;
      out_digit <= E3_MIN;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      carry     <= carry_nxt;
      err       <= err_nxt;
      out_digit <= out_digit_nxt;
      out_last  <= out_last_nxt;
      out_err   <= out_err_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_e3_mult_9_seq.sv
// Directed bench for e3_mult_9_seq; beats are logged as {err,last,digit}.
module tb_e3_mult_9_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_digit = 4'b0011;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] out_digit;
  logic       out_last;
  logic       out_err;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] got_q[$];
  logic [5:0] exp_q[$];

  e3_mult_9_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_digit (out_digit),
    .out_last  (out_last),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // inputs change only at posedge+1, so a negedge view equals the next edge's view
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_err, out_last, out_digit});
  end

  task automatic send(input logic [3:0] d, input logic l);
    int n = 0;
    in_digit = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (got_q.size() < n && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (out_digit !== 4'b0011) begin n_errors++; $display("FAIL reset_out_digit: got %b required 0011", out_digit); end
    if (out_last !== 1'b0) begin n_errors++; $display("FAIL reset_out_last: got %b required 0", out_last); end
    if (out_err !== 1'b0) begin n_errors++; $display("FAIL reset_out_err: got %b required 0", out_err); end
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  // 9 x 9 = 81
  task automatic test_single_nine();
    got_q.delete();
    exp_q = '{6'b0_0_0100, 6'b0_1_1011};
    send(4'b1100, 1'b1);
    wait_beats(exp_q.size());
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL single_nine_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][4:0] !== exp_q[i][4:0] || (exp_q[i][4] && got_q[i][5] !== exp_q[i][5])) begin
        n_errors++;
        $display("FAIL single_nine_beat%0d: got %b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // 25 x 9 = 225
  task automatic test_two_digit();
    got_q.delete();
    exp_q = '{6'b0_0_1000, 6'b0_0_0101, 6'b0_1_0101};
    send(4'b1000, 1'b0);
    send(4'b0101, 1'b1);
    wait_beats(exp_q.size());
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL two_digit_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][4:0] !== exp_q[i][4:0] || (exp_q[i][4] && got_q[i][5] !== exp_q[i][5])) begin
        n_errors++;
        $display("FAIL two_digit_beat%0d: got %b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // 1 x 9 = 9: the final tens digit is zero
  task automatic test_zero_tens();
    got_q.delete();
`ifdef E3_MULT_SEQ_ZERO_SUPPRESS_EN
    exp_q = '{6'b0_1_1100};
`else
    exp_q = '{6'b0_0_1100, 6'b0_1_0011};
`endif
    send(4'b0100, 1'b1);
    wait_beats(exp_q.size());
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL zero_tens_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][4:0] !== exp_q[i][4:0] || (exp_q[i][4] && got_q[i][5] !== exp_q[i][5])) begin
        n_errors++;
        $display("FAIL zero_tens_beat%0d: got %b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // invalid LSD counts as 0 and flags the number; the next number is clean
  task automatic test_invalid_digit();
    got_q.delete();
`ifdef E3_MULT_SEQ_ZERO_SUPPRESS_EN
    exp_q = '{6'b0_0_0011, 6'b1_1_1100, 6'b0_1_1100};
`else
    exp_q = '{6'b0_0_0011, 6'b0_0_1100, 6'b1_1_0011, 6'b0_0_1100, 6'b0_1_0011};
`endif
    send(4'b0000, 1'b0);
    send(4'b0100, 1'b1);
    send(4'b0100, 1'b1);
    wait_beats(exp_q.size());
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL invalid_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][4:0] !== exp_q[i][4:0] || (exp_q[i][4] && got_q[i][5] !== exp_q[i][5])) begin
        n_errors++;
        $display("FAIL invalid_beat%0d: got %b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // 999 x 9 = 8991: maximum carry on every digit
  task automatic test_max_carry();
    got_q.delete();
    exp_q = '{6'b0_0_0100, 6'b0_0_1100, 6'b0_0_1100, 6'b0_1_1011};
    send(4'b1100, 1'b0);
    send(4'b1100, 1'b0);
    send(4'b1100, 1'b1);
    wait_beats(exp_q.size());
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL max_carry_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][4:0] !== exp_q[i][4:0] || (exp_q[i][4] && got_q[i][5] !== exp_q[i][5])) begin
        n_errors++;
        $display("FAIL max_carry_beat%0d: got %b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // 25 x 9 with the consumer stalling for three cycles on the first beat
  task automatic test_stall();
    int t0;
    int cycles;
    got_q.delete();
    exp_q = '{6'b0_0_1000, 6'b0_0_0101, 6'b0_1_0101};
    out_ready = 1'b0;
    send(4'b1000, 1'b0);
    fork
      send(4'b0101, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          n_checks += 3;
          if (out_valid !== 1'b1 || out_digit !== 4'b1000) begin
            n_errors++;
            $display("FAIL stall_hold: valid=%b digit=%b required 1 1000", out_valid, out_digit);
          end
          if (out_last !== 1'b0) begin n_errors++; $display("FAIL stall_last: got %b required 0", out_last); end
          if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    t0 = $time;
    wait_beats(exp_q.size());
    cycles = (int'($time) - t0) / 10;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL stall_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][4:0] !== exp_q[i][4:0] || (exp_q[i][4] && got_q[i][5] !== exp_q[i][5])) begin
        n_errors++;
        $display("FAIL stall_beat%0d: got %b required %b", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (cycles > 6) begin n_errors++; $display("FAIL stall_resume_rate: took %0d cycles required <= 6", cycles); end
  endtask

  // reset mid-number drops the partial product; the next number starts with carry 0
  task automatic test_reset_mid();
    got_q.delete();
    send(4'b1100, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mid_valid: got %b required 0", out_valid); end
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_mid_in_ready: got %b required 1", in_ready); end
    @(posedge clk);
    #1;
    got_q.delete();
`ifdef E3_MULT_SEQ_ZERO_SUPPRESS_EN
    exp_q = '{6'b0_1_1100};
`else
    exp_q = '{6'b0_0_1100, 6'b0_1_0011};
`endif
    send(4'b0100, 1'b1);
    wait_beats(exp_q.size());
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL reset_mid_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][4:0] !== exp_q[i][4:0] || (exp_q[i][4] && got_q[i][5] !== exp_q[i][5])) begin
        n_errors++;
        $display("FAIL reset_mid_beat%0d: got %b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // 9 then 2 back to back: 81 followed by 18
  task automatic test_back_to_back();
    got_q.delete();
    exp_q = '{6'b0_0_0100, 6'b0_1_1011, 6'b0_0_1011, 6'b0_1_0100};
    send(4'b1100, 1'b1);
    send(4'b0101, 1'b1);
    wait_beats(exp_q.size());
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i][4:0] !== exp_q[i][4:0] || (exp_q[i][4] && got_q[i][5] !== exp_q[i][5])) begin
        n_errors++;
        $display("FAIL b2b_beat%0d: got %b required %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_nine();
    test_two_digit();
    test_zero_tens();
    test_invalid_digit();
    test_max_carry();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
